// File: rtl/sr_poll.sv
// rtl/sr_poll.sv - periodic/on-demand status word poller over a req/ack read port
// Holds the last good status word for the Master Control decode, with timeout and freshness flags.
module sr_poll #(
    parameter int          POLL_INTERVAL = 1024,
    parameter int          TIMEOUT       = 256,
    parameter logic [31:0] SR_ADDR       = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        poll_now,
    input  logic        clr_err,
    output logic        rd_req,
    output logic [31:0] rd_addr,
    input  logic        rd_ack,
    input  logic [31:0] rd_data,
    output logic [31:0] sr,
    output logic        sr_valid,
    output logic        sr_update,
    output logic        timeout_err
);

    localparam int IW = (POLL_INTERVAL > 2) ? $clog2(POLL_INTERVAL) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [IW-1:0] IC_LAST = IW'(POLL_INTERVAL - 1);
    localparam logic [TW-1:0] TC_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        READ = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [IW-1:0] ic;
    logic [TW-1:0] tc;
    logic          trigger;
    logic          ack_hit;
    logic          to_hit;

    // poll_now takes effect regardless of enable; the interval only runs while enabled
    assign trigger = (state == IDLE) && (poll_now || (enable && (ic == IC_LAST)));
    assign ack_hit = (state == READ) && rd_ack;
    assign to_hit  = (state == READ) && !rd_ack && (tc == TC_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (trigger) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                if (ack_hit || to_hit) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_req  = 1'b0;
        rd_addr = '0;
        if (state == READ) begin
            rd_req  = 1'b1;
            rd_addr = SR_ADDR;
        end
    end

    // Interval counter sits at 0 outside IDLE so each IDLE visit starts a full interval
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ic <= '0;
        end else if ((state != IDLE) || !enable || trigger) begin
            ic <= '0;
        end else begin
            ic <= ic + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tc <= '0;
        end else if (state != READ) begin
            tc <= '0;
        end else if (!rd_ack && (tc != TC_LAST)) begin
            tc <= tc + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr        <= 32'h0;
            sr_valid  <= 1'b0;
            sr_update <= 1'b0;
        end else begin
            sr_update <= ack_hit;
            if (ack_hit) begin
                sr       <= rd_data;
                sr_valid <= 1'b1;
            end
        end
    end

    // A timeout arriving with a clear keeps the flag set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_err <= 1'b0;
        end else if (to_hit) begin
            timeout_err <= 1'b1;
        end else if (clr_err) begin
            timeout_err <= 1'b0;
        end
    end

endmodule
